// File: rtl/mem_stage_if.sv
// es/ms/ws handshake and payload signals around the memory stage.
// slave is the memory stage's view; master is the surrounding pipeline's view.
interface mem_stage_if #(
  parameter int unsigned ES_BUS_WD = 73,
  parameter int unsigned WS_BUS_WD = 70,
  parameter int unsigned FWD_WD    = 39
);
  logic                 ms_allowin;
  logic                 es_to_ms_valid;
  logic [ES_BUS_WD-1:0] es_to_ms_bus;
  logic                 data_sram_data_ok;
  logic [31:0]          data_sram_rdata;
  logic                 ws_allowin;
  logic                 ms_to_ws_valid;
  logic [WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [FWD_WD-1:0]    ms_to_ds_bus;

  modport slave (
    output ms_allowin,
    input  es_to_ms_valid,
    input  es_to_ms_bus,
    input  data_sram_data_ok,
    input  data_sram_rdata,
    input  ws_allowin,
    output ms_to_ws_valid,
    output ms_to_ws_bus,
    output ms_to_ds_bus
  );

  modport master (
    input  ms_allowin,
    output es_to_ms_valid,
    output es_to_ms_bus,
    output data_sram_data_ok,
    output data_sram_rdata,
    output ws_allowin,
    input  ms_to_ws_valid,
    input  ms_to_ws_bus,
    input  ms_to_ds_bus
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS pipeline memory stage: waits for the data-SRAM read response, buffers it
// across ws stalls, extracts/extends load data and drives ws and forwarding buses.
module mem_stage #(
  parameter int unsigned ES_BUS_WD = 73,
  parameter int unsigned WS_BUS_WD = 70,
  parameter int unsigned FWD_WD    = 39
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  io
);

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LBU  = 3'd2;
  localparam logic [2:0] LD_LH   = 3'd3;
  localparam logic [2:0] LD_LHU  = 3'd4;
  localparam logic [2:0] LD_LW   = 3'd5;

  logic                 ms_valid_q, ms_valid_d;
  logic [ES_BUS_WD-1:0] bus_q, bus_d;
  logic                 rbuf_valid_q, rbuf_valid_d;
  logic [31:0]          rbuf_q, rbuf_d;

  logic [31:0] pc;
  logic [2:0]  ld_type;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] alu_result;
  logic [1:0]  a;

  logic        is_load;
  logic        ready_go;
  logic        allowin;
  logic        fire;
  logic        capture;
  logic [31:0] mem_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic        fwd_blk;

  assign pc         = bus_q[72:41];
  assign ld_type    = bus_q[40:38];
  assign rf_we      = bus_q[37];
  assign rf_addr    = bus_q[36:32];
  assign alu_result = bus_q[31:0];
  assign a          = alu_result[1:0];

  // Handshake: a load is ready once its data is buffered or arriving this cycle.
  always_comb begin
    is_load  = (ld_type != LD_NONE) && (ld_type <= LD_LW);
    ready_go = !is_load || rbuf_valid_q || io.data_sram_data_ok;
    allowin  = !ms_valid_q || (ready_go && io.ws_allowin);
    fire     = ms_valid_q && ready_go && io.ws_allowin;
    capture  = io.data_sram_data_ok && ms_valid_q && is_load && !rbuf_valid_q && !fire;
  end

  // Next state; fire takes priority over a same-cycle capture.
  always_comb begin
    ms_valid_d   = ms_valid_q;
    bus_d        = bus_q;
    rbuf_valid_d = rbuf_valid_q;
    rbuf_d       = rbuf_q;
    if (allowin) begin
      ms_valid_d = io.es_to_ms_valid;
    end
    if (allowin && io.es_to_ms_valid) begin
      bus_d = io.es_to_ms_bus;
    end
    if (fire) begin
      rbuf_valid_d = 1'b0;
    end else if (capture) begin
      rbuf_valid_d = 1'b1;
      rbuf_d       = io.data_sram_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid_q   <= 1'b0;
      bus_q        <= '0;
      rbuf_valid_q <= 1'b0;
      rbuf_q       <= '0;
    end else begin
      ms_valid_q   <= ms_valid_d;
      bus_q        <= bus_d;
      rbuf_valid_q <= rbuf_valid_d;
      rbuf_q       <= rbuf_d;
    end
  end

  // Byte/halfword extraction with the live SRAM word bypassed when nothing is buffered.
  always_comb begin
    mem_word = rbuf_valid_q ? rbuf_q : io.data_sram_rdata;
    case (a)
      2'd0:    byte_sel = mem_word[7:0];
      2'd1:    byte_sel = mem_word[15:8];
      2'd2:    byte_sel = mem_word[23:16];
      default: byte_sel = mem_word[31:24];
    endcase
    half_sel = a[1] ? mem_word[31:16] : mem_word[15:0];
    case (ld_type)
      LD_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  load_data = {24'd0, byte_sel};
      LD_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  load_data = {16'd0, half_sel};
      LD_LW:   load_data = mem_word;
      default: load_data = alu_result;
    endcase
    rf_wdata  = is_load ? load_data : alu_result;
    fwd_valid = ms_valid_q && rf_we && (rf_addr != 5'd0);
    fwd_blk   = ms_valid_q && is_load && !ready_go;
  end

  assign io.ms_allowin     = allowin;
  assign io.ms_to_ws_valid = ms_valid_q && ready_go;
  assign io.ms_to_ws_bus   = WS_BUS_WD'({pc, rf_we, rf_addr, rf_wdata});
  assign io.ms_to_ds_bus   = FWD_WD'({fwd_valid, fwd_blk, rf_addr, rf_wdata});

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, streaming, load extraction, load wait,
// ws stall buffering and reset during an outstanding load.
module tb_mem_stage;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_stage_if bus ();

  mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  logic [31:0] ws_pc;
  logic [31:0] ws_wdata;
  logic        fwd_v;
  logic        fwd_b;
  assign ws_pc    = bus.ms_to_ws_bus[69:38];
  assign ws_wdata = bus.ms_to_ws_bus[31:0];
  assign fwd_v    = bus.ms_to_ds_bus[38];
  assign fwd_b    = bus.ms_to_ds_bus[37];

  function automatic logic [72:0] mk_es(input logic [31:0] pc, input logic [2:0] ld,
                                        input logic we, input logic [4:0] addr,
                                        input logic [31:0] alu);
    return {pc, ld, we, addr, alu};
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.ms_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got %0h want 1", bus.ms_allowin); end
    checks++; if (bus.ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL reset_ws_valid got %0h want 0", bus.ms_to_ws_valid); end
    checks++; if (bus.ms_to_ws_bus !== 70'd0) begin errors++; $display("FAIL reset_ws_bus got %0h want 0", bus.ms_to_ws_bus); end
    checks++; if (bus.ms_to_ds_bus !== 39'd0) begin errors++; $display("FAIL reset_ds_bus got %0h want 0", bus.ms_to_ds_bus); end
    @(posedge clk); #1 bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (bus.ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL spurious_ws_valid got %0h want 0", bus.ms_to_ws_valid); end
    @(posedge clk); #1 bus.data_sram_data_ok = 1'b0; bus.data_sram_rdata = 32'd0;
    @(negedge clk);
    checks++; if (bus.ms_to_ws_bus !== 70'd0) begin errors++; $display("FAIL spurious_ws_bus got %0h want 0", bus.ms_to_ws_bus); end
    checks++; if (bus.ms_allowin !== 1'b1) begin errors++; $display("FAIL spurious_allowin got %0h want 1", bus.ms_allowin); end
  endtask

  task automatic test_stream;
    bus.ws_allowin = 1'b1;
    @(posedge clk); #1 bus.es_to_ms_valid = 1'b1; bus.es_to_ms_bus = mk_es(32'hBFC00000, 3'd0, 1'b1, 5'd3, 32'h12);
    @(posedge clk); #1 bus.es_to_ms_bus = mk_es(32'hBFC00004, 3'd0, 1'b1, 5'd4, 32'h34);
    @(negedge clk);
    checks++; if (bus.ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL stream0_valid got %0h want 1", bus.ms_to_ws_valid); end
    checks++; if (bus.ms_to_ws_bus !== {32'hBFC00000, 1'b1, 5'd3, 32'h12}) begin errors++; $display("FAIL stream0_bus got %0h want %0h", bus.ms_to_ws_bus, {32'hBFC00000, 1'b1, 5'd3, 32'h12}); end
    checks++; if (bus.ms_to_ds_bus !== {1'b1, 1'b0, 5'd3, 32'h12}) begin errors++; $display("FAIL stream0_fwd got %0h want %0h", bus.ms_to_ds_bus, {1'b1, 1'b0, 5'd3, 32'h12}); end
    checks++; if (bus.ms_allowin !== 1'b1) begin errors++; $display("FAIL stream0_allowin got %0h want 1", bus.ms_allowin); end
    @(posedge clk); #1 bus.es_to_ms_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL stream1_valid got %0h want 1", bus.ms_to_ws_valid); end
    checks++; if (ws_pc !== 32'hBFC00004 || ws_wdata !== 32'h34) begin errors++; $display("FAIL stream1_data got pc %0h wdata %0h want bfc00004 34", ws_pc, ws_wdata); end
    checks++; if (bus.ms_allowin !== 1'b1) begin errors++; $display("FAIL stream1_allowin got %0h want 1", bus.ms_allowin); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %0h want 0", bus.ms_to_ws_valid); end
  endtask

  task automatic test_extract;
    logic [2:0]  ld_tab  [8] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd5, 3'd2, 3'd1};
    logic [1:0]  a_tab   [8] = '{2'd3, 2'd3, 2'd0, 2'd2, 2'd0, 2'd0, 2'd2, 2'd1};
    logic [31:0] exp_tab [8] = '{32'hFFFFFF80, 32'h00000080, 32'h00000001, 32'hFFFF80FF,
                                 32'h00007F01, 32'h80FF7F01, 32'h000000FF, 32'h0000007F};
    bus.ws_allowin = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 bus.es_to_ms_valid = 1'b1;
      bus.es_to_ms_bus = mk_es(32'hBFC00100, ld_tab[i], 1'b1, 5'd7, 32'h00002000 | 32'(a_tab[i]));
      @(posedge clk); #1 bus.es_to_ms_valid = 1'b0; bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h80FF7F01;
      @(negedge clk);
      checks++; if (bus.ms_to_ws_valid !== 1'b1 || ws_wdata !== exp_tab[i]) begin errors++; $display("FAIL extract%0d got valid %0h wdata %0h want 1 %0h", i, bus.ms_to_ws_valid, ws_wdata, exp_tab[i]); end
      @(posedge clk); #1 bus.data_sram_data_ok = 1'b0; bus.data_sram_rdata = 32'd0;
      @(negedge clk);
      checks++; if (bus.ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL extract%0d_drain got %0h want 0", i, bus.ms_to_ws_valid); end
    end
  endtask

  task automatic test_load_wait;
    bus.ws_allowin = 1'b1;
    @(posedge clk); #1 bus.es_to_ms_valid = 1'b1; bus.es_to_ms_bus = mk_es(32'hBFC00200, 3'd5, 1'b1, 5'd5, 32'h3000);
    @(posedge clk); #1 bus.es_to_ms_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (bus.ms_allowin !== 1'b0 || fwd_b !== 1'b1 || bus.ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL wait%0d got allowin %0h blk %0h valid %0h want 0 1 0", k, bus.ms_allowin, fwd_b, bus.ms_to_ws_valid); end
      @(posedge clk); #1;
    end
    bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'hCAFEF00D;
    @(negedge clk);
    checks++; if (bus.ms_to_ws_valid !== 1'b1 || fwd_b !== 1'b0 || bus.ms_allowin !== 1'b1) begin errors++; $display("FAIL wait_done got valid %0h blk %0h allowin %0h want 1 0 1", bus.ms_to_ws_valid, fwd_b, bus.ms_allowin); end
    checks++; if (ws_wdata !== 32'hCAFEF00D || fwd_v !== 1'b1) begin errors++; $display("FAIL wait_data got wdata %0h fwd_v %0h want cafef00d 1", ws_wdata, fwd_v); end
    @(posedge clk); #1 bus.data_sram_data_ok = 1'b0;
    @(negedge clk);
    checks++; if (bus.ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL wait_drain got %0h want 0", bus.ms_to_ws_valid); end
  endtask

  task automatic test_ws_stall;
    bus.ws_allowin = 1'b0;
    @(posedge clk); #1 bus.es_to_ms_valid = 1'b1; bus.es_to_ms_bus = mk_es(32'hBFC00300, 3'd5, 1'b1, 5'd6, 32'h4000);
    @(posedge clk); #1 bus.es_to_ms_valid = 1'b0; bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h11223344;
    @(negedge clk);
    checks++; if (bus.ms_to_ws_valid !== 1'b1 || ws_wdata !== 32'h11223344 || bus.ms_allowin !== 1'b0) begin errors++; $display("FAIL stall_ok got valid %0h wdata %0h allowin %0h want 1 11223344 0", bus.ms_to_ws_valid, ws_wdata, bus.ms_allowin); end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1 bus.data_sram_data_ok = 1'b0; bus.data_sram_rdata = 32'd0;
      @(negedge clk);
      checks++; if (bus.ms_to_ws_valid !== 1'b1 || ws_wdata !== 32'h11223344 || bus.ms_allowin !== 1'b0) begin errors++; $display("FAIL stall_hold%0d got valid %0h wdata %0h allowin %0h want 1 11223344 0", k, bus.ms_to_ws_valid, ws_wdata, bus.ms_allowin); end
    end
    @(posedge clk); #1 bus.ws_allowin = 1'b1;
    bus.es_to_ms_valid = 1'b1; bus.es_to_ms_bus = mk_es(32'hBFC00304, 3'd5, 1'b1, 5'd8, 32'h4004);
    @(negedge clk);
    checks++; if (bus.ms_to_ws_valid !== 1'b1 || ws_wdata !== 32'h11223344 || bus.ms_allowin !== 1'b1) begin errors++; $display("FAIL stall_release got valid %0h wdata %0h allowin %0h want 1 11223344 1", bus.ms_to_ws_valid, ws_wdata, bus.ms_allowin); end
    @(posedge clk); #1 bus.es_to_ms_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.ms_to_ws_valid !== 1'b0 || fwd_b !== 1'b1 || bus.ms_allowin !== 1'b0) begin errors++; $display("FAIL rbuf_cleared got valid %0h blk %0h allowin %0h want 0 1 0", bus.ms_to_ws_valid, fwd_b, bus.ms_allowin); end
    @(posedge clk); #1 bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'hA5A50001;
    @(negedge clk);
    checks++; if (bus.ms_to_ws_valid !== 1'b1 || ws_wdata !== 32'hA5A50001 || ws_pc !== 32'hBFC00304) begin errors++; $display("FAIL b2b_load got valid %0h wdata %0h pc %0h want 1 a5a50001 bfc00304", bus.ms_to_ws_valid, ws_wdata, ws_pc); end
    @(posedge clk); #1 bus.data_sram_data_ok = 1'b0; bus.data_sram_rdata = 32'd0;
    @(negedge clk);
    checks++; if (bus.ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0h want 0", bus.ms_to_ws_valid); end
  endtask

  task automatic test_reset_mid_load;
    bus.ws_allowin = 1'b1;
    @(posedge clk); #1 bus.es_to_ms_valid = 1'b1; bus.es_to_ms_bus = mk_es(32'hBFC00400, 3'd5, 1'b1, 5'd9, 32'h5000);
    @(posedge clk); #1 bus.es_to_ms_valid = 1'b0;
    @(negedge clk);
    checks++; if (fwd_b !== 1'b1) begin errors++; $display("FAIL midload_blk got %0h want 1", fwd_b); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.ms_allowin !== 1'b1 || bus.ms_to_ds_bus !== 39'd0 || bus.ms_to_ws_bus !== 70'd0) begin errors++; $display("FAIL async_reset got allowin %0h ds %0h ws %0h want 1 0 0", bus.ms_allowin, bus.ms_to_ds_bus, bus.ms_to_ws_bus); end
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h00000055;
    @(negedge clk);
    checks++; if (bus.ms_to_ws_valid !== 1'b0 || bus.ms_to_ws_bus !== 70'd0) begin errors++; $display("FAIL late_ok got valid %0h bus %0h want 0 0", bus.ms_to_ws_valid, bus.ms_to_ws_bus); end
    @(posedge clk); #1 bus.data_sram_data_ok = 1'b0; bus.data_sram_rdata = 32'd0;
    @(negedge clk);
    checks++; if (bus.ms_to_ws_valid !== 1'b0 || bus.ms_allowin !== 1'b1) begin errors++; $display("FAIL late_ok_after got valid %0h allowin %0h want 0 1", bus.ms_to_ws_valid, bus.ms_allowin); end
  endtask

  initial begin
    reset                 = 1'b1;
    bus.es_to_ms_valid    = 1'b0;
    bus.es_to_ms_bus      = '0;
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = 32'd0;
    bus.ws_allowin        = 1'b1;
    test_reset();
    test_stream();
    test_extract();
    test_load_wait();
    test_ws_stall();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
